// File: rtl/v850_issue_decoder.sv
// V850 decode/issue stage: assembles 16/32-bit instructions from fetch halfwords and drives a registered operand bundle.
// Optional read-after-write interlock is enabled by defining DECODER_HAZARD_STALL_EN.
module v850_issue_decoder #(
    parameter logic [9:0] NOP_SEL = 10'b10_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        hw_valid_i,
    input  logic [15:0] hw_data_i,
    output logic        hw_ready_o,
    input  logic [31:0] gr_i [32],
    output logic [4:0]  destination_o,
    output logic [31:0] reg1_o,
    output logic [31:0] reg2_o,
    output logic [31:0] reg3_o,
    output logic        increment_bit_o,
    output logic [9:0]  circuit_sel_o,
    output logic        issue_valid_o,
    output logic        illegal_o
);

    typedef enum logic {ST_FIRST, ST_SECOND} state_t;

    localparam logic [10:0] DIV_SUBOP = 11'b01011000000;

    state_t      r_state, w_state_next;
    logic [15:0] r_prefix, r_first, r_second;
    logic        r_pend, r_hold, r_ready;

    logic        w_accept, w_is_prefix, w_complete, w_issue, w_haz;
    logic [15:0] w_cmp_first, w_cmp_second;

    logic [5:0]  w_op;
    logic [4:0]  w_r1, w_r2;
    logic [31:0] w_gr1, w_gr2;
    logic        w_legal;
    logic [9:0]  w_sel;
    logic [4:0]  w_dest;
    logic [31:0] w_op1, w_op2, w_op3;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FIRST;
        else        r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (flush_i)       w_state_next = ST_FIRST;
        else if (w_accept) w_state_next = w_is_prefix ? ST_SECOND : ST_FIRST;
    end

    // FSM: outputs towards the datapath
    always_comb begin
        w_accept     = hw_valid_i && r_ready && !flush_i;
        w_is_prefix  = (r_state == ST_FIRST) && (hw_data_i[10:9] == 2'b11);
        w_complete   = w_accept && !w_is_prefix;
        w_cmp_first  = (r_state == ST_SECOND) ? r_prefix  : hw_data_i;
        w_cmp_second = (r_state == ST_SECOND) ? hw_data_i : 16'h0000;
    end

    assign w_issue    = r_pend && !r_hold;
    assign hw_ready_o = r_ready;

    assign w_op  = r_first[10:5];
    assign w_r1  = r_first[4:0];
    assign w_r2  = r_first[15:11];
    assign w_gr1 = (w_r1 == 5'd0) ? 32'h0 : gr_i[w_r1];
    assign w_gr2 = (w_r2 == 5'd0) ? 32'h0 : gr_i[w_r2];

    // Illegal encodings fall through with bubble values
    always_comb begin
        w_legal = 1'b0;
        w_sel   = NOP_SEL;
        w_dest  = 5'd0;
        w_op1   = 32'h0;
        w_op2   = 32'h0;
        w_op3   = 32'h0;
        case (w_op)
            6'b001110: begin w_legal = 1'b1; w_sel = 10'h020; w_op1 = w_gr1; w_op2 = w_gr2; w_dest = w_r2; end
            6'b010010: begin w_legal = 1'b1; w_sel = 10'h020; w_op1 = {{27{w_r1[4]}}, w_r1}; w_op2 = w_gr2; w_dest = w_r2; end
            6'b001101: begin w_legal = 1'b1; w_sel = 10'h000; w_op1 = ~w_gr1 + 32'd1; w_op2 = w_gr2; w_dest = w_r2; end
            6'b001111: begin w_legal = 1'b1; w_sel = 10'h000; w_op1 = ~w_gr1 + 32'd1; w_op2 = w_gr2; end
            6'b001010: begin w_legal = 1'b1; w_sel = 10'h002; w_op1 = w_gr1; w_op2 = w_gr2; w_dest = w_r2; end
            6'b001000: begin w_legal = 1'b1; w_sel = 10'h003; w_op1 = w_gr1; w_op2 = w_gr2; w_dest = w_r2; end
            6'b110000: begin w_legal = 1'b1; w_sel = 10'h020; w_op1 = {{16{r_second[15]}}, r_second}; w_op2 = w_gr1; w_dest = w_r2; end
            6'b110110: begin w_legal = 1'b1; w_sel = 10'h002; w_op1 = {16'h0000, r_second}; w_op2 = w_gr1; w_dest = w_r2; end
            6'b111111: begin
                if (r_second[10:0] == DIV_SUBOP) begin
                    w_legal = 1'b1;
                    w_sel   = 10'h008;
                    w_op1   = w_gr1;
                    w_op2   = w_gr2;
                    w_dest  = w_r2;
                    w_op3   = {27'h0, r_second[15:11]};
                end
            end
            default: ;
        endcase
    end

`ifdef DECODER_HAZARD_STALL_EN
    // Returns {reads reg2 field, reads reg1 field} for a complete instruction
    function automatic logic [1:0] f_reads(input logic [15:0] first, input logic [15:0] second);
        case (first[10:5])
            6'b001110, 6'b001101, 6'b001111, 6'b001010, 6'b001000: f_reads = 2'b11;
            6'b010010:                                             f_reads = 2'b10;
            6'b110000, 6'b110110:                                  f_reads = 2'b01;
            6'b111111: f_reads = (second[10:0] == DIV_SUBOP) ? 2'b11 : 2'b00;
            default:                                               f_reads = 2'b00;
        endcase
    endfunction

    logic [1:0] w_reads;
    logic [4:0] w_src1, w_src2;

    // The instruction completing now would decode next cycle with stale GR if it reads what is issuing now
    always_comb begin
        w_reads = f_reads(w_cmp_first, w_cmp_second);
        w_src1  = w_cmp_first[4:0];
        w_src2  = w_cmp_first[15:11];
        w_haz   = w_complete && w_issue &&
                  ((w_reads[0] && (w_src1 != 5'd0) && ((w_src1 == w_dest) || (w_src1 == w_op3[4:0]))) ||
                   (w_reads[1] && (w_src2 != 5'd0) && ((w_src2 == w_dest) || (w_src2 == w_op3[4:0]))));
    end
`else
    assign w_haz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prefix        <= 16'h0000;
            r_first         <= 16'h0000;
            r_second        <= 16'h0000;
            r_pend          <= 1'b0;
            r_hold          <= 1'b0;
            r_ready         <= 1'b1;
            destination_o   <= 5'd0;
            reg1_o          <= 32'h0;
            reg2_o          <= 32'h0;
            reg3_o          <= 32'h0;
            increment_bit_o <= 1'b0;
            circuit_sel_o   <= NOP_SEL;
            issue_valid_o   <= 1'b0;
            illegal_o       <= 1'b0;
        end else begin
            if (w_accept && w_is_prefix) r_prefix <= hw_data_i;
            if (w_complete) begin
                r_first  <= w_cmp_first;
                r_second <= w_cmp_second;
                r_pend   <= 1'b1;
            end else if (!r_hold) begin
                r_pend   <= 1'b0;
            end
            r_hold          <= w_haz;
            r_ready         <= !w_haz;
            destination_o   <= w_issue ? w_dest : 5'd0;
            reg1_o          <= w_issue ? w_op1  : 32'h0;
            reg2_o          <= w_issue ? w_op2  : 32'h0;
            reg3_o          <= w_issue ? w_op3  : 32'h0;
            increment_bit_o <= 1'b0;
            circuit_sel_o   <= w_issue ? w_sel  : NOP_SEL;
            issue_valid_o   <= w_issue && w_legal;
            illegal_o       <= w_issue && !w_legal;
        end
    end

endmodule

// File: tb/tb_v850_issue_decoder.sv
// Randomized bench for v850_issue_decoder against a cycle-level reference model of the decode rules.
// Define DECODER_HAZARD_STALL_EN for both files to exercise the interlock.
module tb_v850_issue_decoder;

    localparam logic [9:0] NOP_SEL = 10'b10_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        hw_valid_i = 1'b0;
    logic [15:0] hw_data_i = 16'h0;
    logic        hw_ready_o;
    logic [31:0] gr_i [32];
    logic [4:0]  destination_o;
    logic [31:0] reg1_o, reg2_o, reg3_o;
    logic        increment_bit_o;
    logic [9:0]  circuit_sel_o;
    logic        issue_valid_o, illegal_o;

    always #5 clk = ~clk;

    v850_issue_decoder #(.NOP_SEL(NOP_SEL)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .hw_valid_i(hw_valid_i), .hw_data_i(hw_data_i), .hw_ready_o(hw_ready_o),
        .gr_i(gr_i), .destination_o(destination_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
        .increment_bit_o(increment_bit_o), .circuit_sel_o(circuit_sel_o),
        .issue_valid_o(issue_valid_o), .illegal_o(illegal_o)
    );

    typedef struct packed {
        logic [9:0]  sel;
        logic        valid;
        logic [4:0]  dest;
        logic [31:0] r1, r2, r3;
        logic        ill;
    } bundle_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] tb_gr [32];
    bit          m_part, m_pend, m_hold, m_ready;
    logic [15:0] m_prefix, m_first, m_second;
    bundle_t     exp_b;
    logic [15:0] q_hw [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic bundle_t bubble();
        bundle_t b;
        b = '0;
        b.sel = NOP_SEL;
        return b;
    endfunction

    function automatic logic [31:0] g(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : tb_gr[r];
    endfunction

    // Decode table in terms of the instruction set, using the GR values visible now
    function automatic bundle_t ref_decode(input logic [15:0] f, input logic [15:0] s);
        bundle_t b;
        logic [4:0] ra, rb;
        ra = f[4:0];
        rb = f[15:11];
        b = bubble();
        b.ill = 1'b1;
        case (f[10:5])
            6'b001110: begin b.sel = 10'h020; b.r1 = g(ra); b.r2 = g(rb); b.dest = rb; end
            6'b010010: begin b.sel = 10'h020; b.r1 = int'($signed(ra)); b.r2 = g(rb); b.dest = rb; end
            6'b001101: begin b.sel = 10'h000; b.r1 = 32'h0 - g(ra); b.r2 = g(rb); b.dest = rb; end
            6'b001111: begin b.sel = 10'h000; b.r1 = 32'h0 - g(ra); b.r2 = g(rb); b.dest = 5'd0; end
            6'b001010: begin b.sel = 10'h002; b.r1 = g(ra); b.r2 = g(rb); b.dest = rb; end
            6'b001000: begin b.sel = 10'h003; b.r1 = g(ra); b.r2 = g(rb); b.dest = rb; end
            6'b110000: begin b.sel = 10'h020; b.r1 = int'($signed(s)); b.r2 = g(ra); b.dest = rb; end
            6'b110110: begin b.sel = 10'h002; b.r1 = 32'(s); b.r2 = g(ra); b.dest = rb; end
            6'b111111: if (s[10:0] == 11'b01011000000) begin
                b.sel = 10'h008; b.r1 = g(ra); b.r2 = g(rb); b.dest = rb; b.r3 = 32'(s[15:11]);
            end
            default: ;
        endcase
        if (b.sel != NOP_SEL) begin
            b.valid = 1'b1;
            b.ill   = 1'b0;
        end
        return b;
    endfunction

`ifdef DECODER_HAZARD_STALL_EN
    function automatic bit reads_reg(input logic [15:0] f, input logic [15:0] s, input logic [4:0] r);
        bit rd_a, rd_b;
        rd_a = 0;
        rd_b = 0;
        case (f[10:5])
            6'b001110, 6'b001101, 6'b001111, 6'b001010, 6'b001000: begin rd_a = 1; rd_b = 1; end
            6'b010010: rd_b = 1;
            6'b110000, 6'b110110: rd_a = 1;
            6'b111111: if (s[10:0] == 11'b01011000000) begin rd_a = 1; rd_b = 1; end
            default: ;
        endcase
        return (r != 5'd0) && ((rd_a && f[4:0] == r) || (rd_b && f[15:11] == r));
    endfunction
`endif

    task automatic check_outputs(input string p);
        chk({p, "_sel"},   32'(circuit_sel_o),   32'(exp_b.sel));
        chk({p, "_valid"}, 32'(issue_valid_o),   32'(exp_b.valid));
        chk({p, "_dest"},  32'(destination_o),   32'(exp_b.dest));
        chk({p, "_reg1"},  reg1_o,               exp_b.r1);
        chk({p, "_reg2"},  reg2_o,               exp_b.r2);
        chk({p, "_reg3"},  reg3_o,               exp_b.r3);
        chk({p, "_ill"},   32'(illegal_o),       32'(exp_b.ill));
        chk({p, "_inc"},   32'(increment_bit_o), 32'h0);
        chk({p, "_ready"}, 32'(hw_ready_o),      32'(m_ready));
    endtask

    task automatic model_reset();
        m_part = 0; m_pend = 0; m_hold = 0; m_ready = 1;
        m_prefix = '0; m_first = '0; m_second = '0;
        exp_b = bubble();
    endtask

    // One clock: check the previous edge's result, drive inputs, predict the next edge
    task automatic step(input bit v, input logic [15:0] h, input bit fl);
        bundle_t     nb;
        bit          issuing, acc, cplt, haz;
        logic [15:0] cf, cs;
        @(negedge clk);
        check_outputs("cyc");
        hw_valid_i = v;
        hw_data_i  = h;
        flush_i    = fl;
        for (int i = 0; i < 32; i++) gr_i[i] = tb_gr[i];
        $display("xact t=%0t v=%0b hw=%h fl=%0b rdy=%0b -> sel=%h iv=%0b ill=%0b",
                 $time, v, h, fl, m_ready, circuit_sel_o, issue_valid_o, illegal_o);
        issuing = m_pend && !m_hold;
        nb      = issuing ? ref_decode(m_first, m_second) : bubble();
        acc     = v && m_ready && !fl;
        cplt    = acc && (m_part || h[10:9] != 2'b11);
        cf      = m_part ? m_prefix : h;
        cs      = m_part ? h : 16'h0;
        haz     = 0;
`ifdef DECODER_HAZARD_STALL_EN
        if (cplt && issuing && nb.valid)
            haz = reads_reg(cf, cs, nb.dest) || reads_reg(cf, cs, nb.r3[4:0]);
`endif
        if (fl) m_part = 0;
        else if (acc) begin
            if (m_part) m_part = 0;
            else if (h[10:9] == 2'b11) begin m_part = 1; m_prefix = h; end
        end
        if (cplt) begin m_pend = 1; m_first = cf; m_second = cs; end
        else if (!m_hold) m_pend = 0;
        m_hold  = haz;
        m_ready = !haz;
        exp_b   = nb;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [15:0] mk(input logic [4:0] r2, input logic [5:0] op, input logic [4:0] r1);
        return {r2, op, r1};
    endfunction

    task automatic gen_instr();
        logic [5:0] ops [9];
        int k;
        logic [15:0] h;
        ops = '{6'b001110, 6'b010010, 6'b001101, 6'b001111, 6'b001010,
                6'b001000, 6'b110000, 6'b110110, 6'b111111};
        k = $urandom_range(0, 9);
        if (k < 9) begin
            q_hw.push_back(mk(5'($urandom_range(0, 7)), ops[k], 5'($urandom_range(0, 7))));
            if (k == 8) begin
                if ($urandom_range(0, 3) != 0) q_hw.push_back({5'($urandom), 11'b01011000000});
                else                           q_hw.push_back(16'($urandom));
            end else if (k >= 6) q_hw.push_back(16'($urandom));
        end else begin
            h = 16'($urandom);
            q_hw.push_back(h);
            if (h[10:9] == 2'b11) q_hw.push_back(16'($urandom));
        end
    endtask

    initial begin
        bit v, fl, pop;
        model_reset();
        for (int i = 0; i < 32; i++) tb_gr[i] = $urandom();
        tb_gr[0] = 32'hDEAD_BEEF;
        tb_gr[3] = 32'd5;
        tb_gr[4] = 32'd7;
        tb_gr[1] = 32'd10;
        for (int i = 0; i < 32; i++) gr_i[i] = tb_gr[i];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD r2=3, r1=4
        step(1, mk(5'd3, 6'b001110, 5'd4), 0);
        step(0, 16'h0, 0);
        #1;
        chk("add_sel", 32'(circuit_sel_o), 32'h020);
        chk("add_reg1", reg1_o, 32'd7);
        chk("add_reg2", reg2_o, 32'd5);
        chk("add_dest", 32'(destination_o), 32'd3);

        // ADDI imm16=0xFFFE, r1=1, r2=2
        step(1, mk(5'd2, 6'b110000, 5'd1), 0);
        step(1, 16'hFFFE, 0);
        #1 chk("addi_first_bubble", 32'(issue_valid_o), 32'h0);
        step(0, 16'h0, 0);
        #1;
        chk("addi_reg1", reg1_o, 32'hFFFF_FFFE);
        chk("addi_reg2", reg2_o, 32'd10);
        chk("addi_dest", 32'(destination_o), 32'd2);

        // SUB then CMP with GR1=1
        tb_gr[1] = 32'd1;
        step(1, mk(5'd6, 6'b001101, 5'd1), 0);
        step(1, mk(5'd6, 6'b001111, 5'd1), 0);
        #1;
        chk("sub_reg1", reg1_o, 32'hFFFF_FFFF);
        chk("sub_sel", 32'(circuit_sel_o), 32'h000);
        step(0, 16'h0, 0);
        #1;
        chk("cmp_dest", 32'(destination_o), 32'd0);
        chk("cmp_valid", 32'(issue_valid_o), 32'd1);

        // Illegal opcode then AND
        step(1, mk(5'd0, 6'b000001, 5'd0), 0);
        step(1, mk(5'd3, 6'b001010, 5'd4), 0);
        #1;
        chk("ill_pulse", 32'(illegal_o), 32'd1);
        chk("ill_sel", 32'(circuit_sel_o), 32'(NOP_SEL));
        step(0, 16'h0, 0);
        #1;
        chk("and_sel", 32'(circuit_sel_o), 32'h002);
        chk("and_ill", 32'(illegal_o), 32'd0);

        // Prefix, flush, then ADD
        step(1, mk(5'd2, 6'b110000, 5'd1), 0);
        step(1, 16'h1234, 1);
        step(1, mk(5'd3, 6'b001110, 5'd4), 0);
        step(0, 16'h0, 0);
        #1;
        chk("flush_add_sel", 32'(circuit_sel_o), 32'h020);
        chk("flush_add_dest", 32'(destination_o), 32'd3);

        // Reset while a prefix is latched
        step(1, mk(5'd2, 6'b110110, 5'd1), 0);
        do_reset();
        step(1, mk(5'd3, 6'b001110, 5'd4), 0);
        step(0, 16'h0, 0);
        #1 chk("rst_add_sel", 32'(circuit_sel_o), 32'h020);

`ifdef DECODER_HAZARD_STALL_EN
        // ADD into r5, then OR reading r5
        step(1, mk(5'd5, 6'b001110, 5'd4), 0);
        step(1, mk(5'd0, 6'b001000, 5'd5), 0);
        #1 chk("haz_ready", 32'(hw_ready_o), 32'd0);
        step(0, 16'h0, 0);
        #1 chk("haz_bubble", 32'(issue_valid_o), 32'd0);
        tb_gr[5] = 32'h0BAD_F00D;
        step(0, 16'h0, 0);
        #1;
        chk("haz_or_sel", 32'(circuit_sel_o), 32'h003);
        chk("haz_or_reg1", reg1_o, 32'h0BAD_F00D);
`endif

        // Randomized stream
        for (int n = 0; n < 800; n++) begin
            if (q_hw.size() == 0) gen_instr();
            v  = ($urandom_range(0, 99) < 85);
            fl = ($urandom_range(0, 99) < 4);
            for (int k = 0; k < 2; k++) tb_gr[$urandom_range(1, 31)] = $urandom();
            pop = v && m_ready;
            step(v, q_hw[0], fl);
            if (pop) void'(q_hw.pop_front());
            if (n == 400) do_reset();
        end
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
